// File: rtl/config_arb_pkg.sv
// Shared types and constants for the configuration source arbiter:
// ownership state encoding, CRC-32 constants and arbitration mode codes.
package config_arb_pkg;

  // Ownership lifecycle of the write path
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    RELEASE = 2'd2
  } arbState_e;

  // CRC-32 (MSB-first, non-reflected, no final XOR)
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  // Arbitration mode encodings for the PRIORITY_MODE parameter
  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  // Advance the CRC register by one data bit
  function automatic logic [31:0] crcStep(input logic [31:0] crcIn, input logic dataBit);
    logic feedback;
    feedback = crcIn[31] ^ dataBit;
    crcStep  = {crcIn[30:0], 1'b0} ^ (feedback ? CRC_POLY : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/config_rr_arbiter.sv
// Combinational request picker: lowest set index in fixed mode, or first set
// index at/after the pointer (wrapping) in round-robin mode.
module config_rr_arbiter
  import config_arb_pkg::*;
#(
  parameter int NUM_SOURCES = 3,
  parameter int OWNER_WIDTH = $clog2(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] req,
  input  logic [OWNER_WIDTH-1:0] ptr,
  input  logic                   rrMode,
  output logic [OWNER_WIDTH-1:0] grantIdx,
  output logic                   grantValid
);

  int cand;

  // Scan candidates starting at 0 (fixed) or at the pointer (round-robin)
  always_comb begin
    grantIdx   = '0;
    grantValid = 1'b0;
    cand       = 0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      cand = rrMode ? (int'(ptr) + k) : k;
      if (cand >= NUM_SOURCES) begin
        cand = cand - NUM_SOURCES;
      end
      if (!grantValid && req[cand]) begin
        grantValid = 1'b1;
        grantIdx   = OWNER_WIDTH'(cand);
      end
    end
  end

endmodule

// File: rtl/config_source_arbiter.sv
// N-source configuration write front-end. One source owns the write path at a
// time; ownership is handed over through a hold-off window and each new grant
// pulses FSM_Reset. Optional CRC-32 over forwarded words: CONFIG_ARB_CRC_EN.
module config_source_arbiter
  import config_arb_pkg::*;
#(
  parameter int NUM_SOURCES        = 3,
  parameter int DATA_WIDTH         = 32,
  parameter int PRIORITY_MODE      = 0,
  parameter int RELEASE_CYCLES     = 16,
  parameter int LED_STRETCH_CYCLES = 1_000_000,
  parameter int OWNER_WIDTH        = $clog2(NUM_SOURCES)
) (
  input  logic                              CLK,
  input  logic                              resetn,
  input  logic [NUM_SOURCES-1:0]            SrcActive,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] SrcWriteData,
  input  logic [NUM_SOURCES-1:0]            SrcWriteStrobe,
  output logic [DATA_WIDTH-1:0]             ConfigWriteData,
  output logic                              ConfigWriteStrobe,
  output logic                              FSM_Reset,
  output logic                              ComActive,
  output logic [OWNER_WIDTH-1:0]            Owner,
  output logic                              OwnerValid,
  output logic                              DroppedStrobe,
  output logic                              ReceiveLED
`ifdef CONFIG_ARB_CRC_EN
  ,
  output logic [31:0]                       ConfigCRC
`endif
);

  localparam int CNT_W = (RELEASE_CYCLES < 1) ? 1 : $clog2(RELEASE_CYCLES + 1);
  localparam int LED_W = (LED_STRETCH_CYCLES < 1) ? 1 : $clog2(LED_STRETCH_CYCLES + 1);
  localparam logic RR_MODE = (PRIORITY_MODE == PRIO_RR);

  arbState_e              state;
  arbState_e              stateNext;
  logic [CNT_W-1:0]       relCnt;
  logic [CNT_W-1:0]       relCntNext;
  logic [OWNER_WIDTH-1:0] ownerNext;
  logic [OWNER_WIDTH-1:0] rrPtr;
  logic [OWNER_WIDTH-1:0] rrPtrNext;
  logic [OWNER_WIDTH-1:0] ownerSucc;
  logic [LED_W-1:0]       ledCnt;

  logic [OWNER_WIDTH-1:0] arbIdx;
  logic                   arbValid;

  logic                   grantPulse;
  logic                   fwdStrobe;
  logic                   dropNext;

  logic [DATA_WIDTH-1:0]  srcWord [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] ownerMask;
  logic [DATA_WIDTH-1:0]  ownerWord;
  logic                   ownerStrobe;
  logic                   ownerActive;

  // Unpack the flat data bus into one word per source
  for (genvar i = 0; i < NUM_SOURCES; i++) begin : gUnpack
    assign srcWord[i] = SrcWriteData[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Owner-selected views of the source inputs and the owner one-hot mask
  always_comb begin
    ownerMask = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      ownerMask[i] = (Owner == OWNER_WIDTH'(i));
    end
    ownerWord   = srcWord[Owner];
    ownerStrobe = SrcWriteStrobe[Owner];
    ownerActive = SrcActive[Owner];
    ownerSucc   = (Owner == OWNER_WIDTH'(NUM_SOURCES - 1)) ? '0 : Owner + OWNER_WIDTH'(1);
  end

  config_rr_arbiter #(
    .NUM_SOURCES(NUM_SOURCES),
    .OWNER_WIDTH(OWNER_WIDTH)
  ) uArbiter (
    .req       (SrcActive),
    .ptr       (rrPtr),
    .rrMode    (RR_MODE),
    .grantIdx  (arbIdx),
    .grantValid(arbValid)
  );

  // Next-state logic: grant, forward, hold-off countdown and handover
  always_comb begin
    stateNext  = state;
    relCntNext = relCnt;
    ownerNext  = Owner;
    rrPtrNext  = rrPtr;
    grantPulse = 1'b0;
    fwdStrobe  = 1'b0;
    dropNext   = 1'b0;
    case (state)
      IDLE: begin
        dropNext = |SrcWriteStrobe;
        if (arbValid) begin
          stateNext  = OWNED;
          ownerNext  = arbIdx;
          grantPulse = 1'b1;
        end
      end
      OWNED: begin
        fwdStrobe = ownerStrobe;
        dropNext  = |(SrcWriteStrobe & ~ownerMask);
        if (!ownerActive) begin
          if (RELEASE_CYCLES == 0) begin
            stateNext = IDLE;
            if (RR_MODE) rrPtrNext = ownerSucc;
          end else begin
            stateNext  = RELEASE;
            relCntNext = CNT_W'(RELEASE_CYCLES);
          end
        end
      end
      RELEASE: begin
        dropNext = |SrcWriteStrobe;
        if (ownerActive) begin
          stateNext = OWNED;
        end else if (relCnt <= CNT_W'(1)) begin
          stateNext  = IDLE;
          relCntNext = '0;
          if (RR_MODE) rrPtrNext = ownerSucc;
        end else begin
          relCntNext = relCnt - CNT_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State, owner, round-robin pointer and hold-off counter registers
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      relCnt <= '0;
      Owner  <= '0;
      rrPtr  <= '0;
    end else begin
      state  <= stateNext;
      relCnt <= relCntNext;
      Owner  <= ownerNext;
      rrPtr  <= rrPtrNext;
    end
  end

  // Registered forwarding path; data holds its last value between strobes
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      ConfigWriteData   <= '0;
      ConfigWriteStrobe <= 1'b0;
      FSM_Reset         <= 1'b0;
      DroppedStrobe     <= 1'b0;
    end else begin
      ConfigWriteStrobe <= fwdStrobe;
      FSM_Reset         <= grantPulse;
      DroppedStrobe     <= dropNext;
      if (fwdStrobe) begin
        ConfigWriteData <= ownerWord;
      end
    end
  end

  // Retriggerable activity stretcher for the receive LED
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      ledCnt <= '0;
    end else if (fwdStrobe) begin
      ledCnt <= LED_W'(LED_STRETCH_CYCLES);
    end else if (ledCnt != '0) begin
      ledCnt <= ledCnt - LED_W'(1);
    end
  end

  assign ReceiveLED = (ledCnt != '0);
  assign ComActive  = (state != IDLE);
  assign OwnerValid = (state == OWNED);

`ifdef CONFIG_ARB_CRC_EN
  // Fold one whole data word into the CRC, MSB first
  function automatic logic [31:0] crcWord(input logic [31:0] crcIn,
                                          input logic [DATA_WIDTH-1:0] word);
    logic [31:0] c;
    c = crcIn;
    for (int b = DATA_WIDTH - 1; b >= 0; b--) begin
      c = crcStep(c, word[b]);
    end
    return c;
  endfunction

  // Running CRC of the current session: restarts on grant, held otherwise
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      ConfigCRC <= CRC_INIT;
    end else if (grantPulse) begin
      ConfigCRC <= CRC_INIT;
    end else if (fwdStrobe) begin
      ConfigCRC <= crcWord(ConfigCRC, ownerWord);
    end
  end
`endif

endmodule

// File: tb/tb_config_source_arbiter.sv
// Directed bench for config_source_arbiter: a fixed-priority instance with a
// short LED stretch, and a round-robin instance with no hold-off window.
// Build with CONFIG_ARB_CRC_EN defined to also check the session CRC.
module tb_config_source_arbiter;

  logic        clk;
  logic        resetn;

  logic [2:0]  fAct;
  logic [2:0]  fStb;
  logic [95:0] fData;
  logic [31:0] fCwData;
  logic        fCwStb;
  logic        fFsmReset;
  logic        fComActive;
  logic [1:0]  fOwner;
  logic        fOwnerValid;
  logic        fDropped;
  logic        fLed;

  logic [2:0]  rAct;
  logic [2:0]  rStb;
  logic [95:0] rData;
  logic [31:0] rCwData;
  logic        rCwStb;
  logic        rFsmReset;
  logic        rComActive;
  logic [1:0]  rOwner;
  logic        rOwnerValid;
  logic        rDropped;
  logic        rLed;

`ifdef CONFIG_ARB_CRC_EN
  logic [31:0] fCrc;
  logic [31:0] rCrc;
`endif

  int checkCount;
  int failCount;

  config_source_arbiter #(
    .NUM_SOURCES(3), .DATA_WIDTH(32), .PRIORITY_MODE(0),
    .RELEASE_CYCLES(16), .LED_STRETCH_CYCLES(4)
  ) dutFix (
    .CLK(clk), .resetn(resetn),
    .SrcActive(fAct), .SrcWriteData(fData), .SrcWriteStrobe(fStb),
    .ConfigWriteData(fCwData), .ConfigWriteStrobe(fCwStb),
    .FSM_Reset(fFsmReset), .ComActive(fComActive), .Owner(fOwner),
    .OwnerValid(fOwnerValid), .DroppedStrobe(fDropped), .ReceiveLED(fLed)
`ifdef CONFIG_ARB_CRC_EN
    , .ConfigCRC(fCrc)
`endif
  );

  config_source_arbiter #(
    .NUM_SOURCES(3), .DATA_WIDTH(32), .PRIORITY_MODE(1),
    .RELEASE_CYCLES(0), .LED_STRETCH_CYCLES(4)
  ) dutRr (
    .CLK(clk), .resetn(resetn),
    .SrcActive(rAct), .SrcWriteData(rData), .SrcWriteStrobe(rStb),
    .ConfigWriteData(rCwData), .ConfigWriteStrobe(rCwStb),
    .FSM_Reset(rFsmReset), .ComActive(rComActive), .Owner(rOwner),
    .OwnerValid(rOwnerValid), .DroppedStrobe(rDropped), .ReceiveLED(rLed)
`ifdef CONFIG_ARB_CRC_EN
    , .ConfigCRC(rCrc)
`endif
  );

  // Free-running system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive the fixed-priority instance for one clock, then settle past the edge
  task automatic applyStimulus(input logic [2:0] act, input logic [2:0] stb,
                               input logic [31:0] word);
    fAct  = act;
    fStb  = stb;
    fData = {word, word, word};
    @(posedge clk);
    #1;
  endtask

  // Drive the round-robin instance for one clock
  task automatic rrStep(input logic [2:0] act);
    rAct = act;
    @(posedge clk);
    #1;
  endtask

  // Main directed sequence
  initial begin
    checkCount = 0;
    failCount  = 0;
    fAct = '0; fStb = '0; fData = '0;
    rAct = '0; rStb = '0; rData = '0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1;
    checkOutput("rst_cwdata", fCwData, 32'h0);
    checkOutput("rst_cwstb", 32'(fCwStb), 32'h0);
    checkOutput("rst_fsmreset", 32'(fFsmReset), 32'h0);
    checkOutput("rst_comactive", 32'(fComActive), 32'h0);
    checkOutput("rst_owner", 32'(fOwner), 32'h0);
    checkOutput("rst_ownervalid", 32'(fOwnerValid), 32'h0);
    checkOutput("rst_dropped", 32'(fDropped), 32'h0);
    checkOutput("rst_led", 32'(fLed), 32'h0);
`ifdef CONFIG_ARB_CRC_EN
    checkOutput("rst_crc", fCrc, 32'hFFFF_FFFF);
`endif
    @(posedge clk);
    @(posedge clk);
    #3 resetn = 1'b1;

    // Fixed priority: src1 beats src2, grant pulse lasts one cycle
    applyStimulus(3'b110, 3'b000, 32'h0);
    checkOutput("grant_owner", 32'(fOwner), 32'h1);
    checkOutput("grant_fsmreset", 32'(fFsmReset), 32'h1);
    checkOutput("grant_ownervalid", 32'(fOwnerValid), 32'h1);
    checkOutput("grant_comactive", 32'(fComActive), 32'h1);
    applyStimulus(3'b110, 3'b000, 32'h0);
    checkOutput("grant_pulse_end", 32'(fFsmReset), 32'h0);

    // Owner write forwarded one cycle later, then data holds
    applyStimulus(3'b110, 3'b010, 32'hDEAD_BEEF);
    checkOutput("fwd_stb", 32'(fCwStb), 32'h1);
    checkOutput("fwd_data", fCwData, 32'hDEAD_BEEF);
    checkOutput("fwd_led", 32'(fLed), 32'h1);
    checkOutput("fwd_nodrop", 32'(fDropped), 32'h0);
    applyStimulus(3'b110, 3'b000, 32'h0);
    checkOutput("hold_stb", 32'(fCwStb), 32'h0);
    checkOutput("hold_data", fCwData, 32'hDEAD_BEEF);

    // Non-owner strobes are discarded
    applyStimulus(3'b110, 3'b001, 32'h1111_1111);
    checkOutput("drop0_pulse", 32'(fDropped), 32'h1);
    checkOutput("drop0_stb", 32'(fCwStb), 32'h0);
    checkOutput("drop0_data", fCwData, 32'hDEAD_BEEF);
    applyStimulus(3'b110, 3'b100, 32'h2222_2222);
    checkOutput("drop2_pulse", 32'(fDropped), 32'h1);
    checkOutput("drop2_stb", 32'(fCwStb), 32'h0);
    checkOutput("drop2_data", fCwData, 32'hDEAD_BEEF);
    applyStimulus(3'b110, 3'b000, 32'h0);
    checkOutput("drop_end", 32'(fDropped), 32'h0);
    checkOutput("led_expired", 32'(fLed), 32'h0);

    // Deassert with a final strobe: still forwarded, then hold-off
    applyStimulus(3'b100, 3'b010, 32'h1234_5678);
    checkOutput("last_stb", 32'(fCwStb), 32'h1);
    checkOutput("last_data", fCwData, 32'h1234_5678);
    checkOutput("rel_ownervalid", 32'(fOwnerValid), 32'h0);
    checkOutput("rel_comactive", 32'(fComActive), 32'h1);
    applyStimulus(3'b100, 3'b010, 32'h3333_3333);
    checkOutput("rel_drop", 32'(fDropped), 32'h1);
    checkOutput("rel_nofwd", 32'(fCwStb), 32'h0);
    checkOutput("rel_data", fCwData, 32'h1234_5678);
    for (int i = 0; i < 3; i++) applyStimulus(3'b100, 3'b000, 32'h0);
    checkOutput("rel_still_active", 32'(fComActive), 32'h1);

    // Owner returns during hold-off: back to OWNED without a grant pulse
    applyStimulus(3'b110, 3'b000, 32'h0);
    checkOutput("reown_valid", 32'(fOwnerValid), 32'h1);
    checkOutput("reown_fsmreset", 32'(fFsmReset), 32'h0);
    checkOutput("reown_owner", 32'(fOwner), 32'h1);

    // Owner leaves for good: 16 hold-off cycles, then IDLE
    applyStimulus(3'b000, 3'b000, 32'h0);
    for (int i = 0; i < 15; i++) applyStimulus(3'b000, 3'b000, 32'h0);
    checkOutput("holdoff_last", 32'(fComActive), 32'h1);
    applyStimulus(3'b000, 3'b000, 32'h0);
    checkOutput("idle_comactive", 32'(fComActive), 32'h0);
    checkOutput("idle_owner_kept", 32'(fOwner), 32'h1);
    checkOutput("idle_ownervalid", 32'(fOwnerValid), 32'h0);

    // Strobe in the grant cycle is dropped
    applyStimulus(3'b001, 3'b001, 32'h5555_5555);
    checkOutput("g0_fsmreset", 32'(fFsmReset), 32'h1);
    checkOutput("g0_owner", 32'(fOwner), 32'h0);
    checkOutput("g0_drop", 32'(fDropped), 32'h1);
    checkOutput("g0_nofwd", 32'(fCwStb), 32'h0);

    // Reset in the middle of a write
    applyStimulus(3'b001, 3'b001, 32'hAAAA_5555);
    checkOutput("mid_stb", 32'(fCwStb), 32'h1);
    fStb = 3'b000;
    #1 resetn = 1'b0;
    #1;
    checkOutput("async_cwdata", fCwData, 32'h0);
    checkOutput("async_cwstb", 32'(fCwStb), 32'h0);
    checkOutput("async_comactive", 32'(fComActive), 32'h0);
    checkOutput("async_led", 32'(fLed), 32'h0);
    checkOutput("async_ownervalid", 32'(fOwnerValid), 32'h0);
    #1 resetn = 1'b1;
    applyStimulus(3'b001, 3'b000, 32'h0);
    checkOutput("regrant_fsmreset", 32'(fFsmReset), 32'h1);
    checkOutput("regrant_owner", 32'(fOwner), 32'h0);
    checkOutput("regrant_valid", 32'(fOwnerValid), 32'h1);
    applyStimulus(3'b001, 3'b001, 32'h0000_0000);
    checkOutput("zero_stb", 32'(fCwStb), 32'h1);
    checkOutput("zero_data", fCwData, 32'h0);
`ifdef CONFIG_ARB_CRC_EN
    checkOutput("crc_zero_word", fCrc, 32'hC704_DD7B);
`endif

    // Round-robin: each owner briefly drops, grants rotate 0,1,2,0
    rrStep(3'b111);
    checkOutput("rr_g0_owner", 32'(rOwner), 32'h0);
    checkOutput("rr_g0_fsmreset", 32'(rFsmReset), 32'h1);
    rrStep(3'b110);
    checkOutput("rr_idle0", 32'(rComActive), 32'h0);
    rrStep(3'b111);
    checkOutput("rr_g1_owner", 32'(rOwner), 32'h1);
    checkOutput("rr_g1_fsmreset", 32'(rFsmReset), 32'h1);
    rrStep(3'b101);
    checkOutput("rr_idle1", 32'(rComActive), 32'h0);
    rrStep(3'b111);
    checkOutput("rr_g2_owner", 32'(rOwner), 32'h2);
    rrStep(3'b011);
    checkOutput("rr_idle2", 32'(rComActive), 32'h0);
    rrStep(3'b111);
    checkOutput("rr_g3_owner", 32'(rOwner), 32'h0);
    checkOutput("rr_g3_valid", 32'(rOwnerValid), 32'h1);

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule
